// File: rtl/router_ctrl.sv
// Packet controller for three output FIFOs: header decode, header/payload write sequencing, length/parity check,
// per-port unread watchdog. Header written 1 cycle after acceptance; busy holds the source while waiting, stalled or checking.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic [7:0] fifo_din,
  output logic       lfd_state,
  output logic       busy,
  output logic [2:0] valid_out,
  output logic [2:0] soft_reset,
  output logic       parity_err,
  output logic       len_err
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, CHECK_PARITY, DROP
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t     state;
  logic [1:0] addr_reg;
  logic [7:0] hdr_reg;
  logic [7:0] par_acc;
  logic [5:0] len_cnt;
  logic [7:0] par_byte;
  logic [CW-1:0] wd_cnt [3];

  // Padded to four entries so a 2-bit address always indexes in range.
  logic [3:0] full_pad, empty_pad, srst_pad;
  logic       act_full, act_srst;

  assign full_pad  = {1'b0, fifo_full};
  assign empty_pad = {1'b0, fifo_empty};
  assign srst_pad  = {1'b0, soft_reset};
  assign act_full  = full_pad[addr_reg];
  assign act_srst  = srst_pad[addr_reg];
  assign valid_out = ~fifo_empty;

  always_comb begin
    write_enb = 3'b000;
    fifo_din  = data_in;
    lfd_state = 1'b0;
    busy      = 1'b0;
    case (state)
      WAIT_TILL_EMPTY: busy = 1'b1;
      LOAD_FIRST_DATA: begin
        busy      = 1'b1;
        fifo_din  = hdr_reg;
        lfd_state = 1'b1;
        if (!act_srst) write_enb = 3'b001 << addr_reg;
      end
      LOAD_DATA: begin
        busy = act_full | act_srst;
        if (!act_full && !act_srst) write_enb = 3'b001 << addr_reg;
      end
      CHECK_PARITY: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= DECODE_ADDRESS;
      addr_reg   <= 2'd0;
      hdr_reg    <= 8'd0;
      par_acc    <= 8'd0;
      len_cnt    <= 6'd0;
      par_byte   <= 8'd0;
      parity_err <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (data_in[1:0] != 2'd3) begin
              addr_reg <= data_in[1:0];
              hdr_reg  <= data_in;
              par_acc  <= data_in;
              len_cnt  <= 6'd0;
              state    <= empty_pad[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end else begin
              state <= DROP;
            end
          end
        end
        WAIT_TILL_EMPTY: begin
          if (act_srst) state <= DROP;
          else if (empty_pad[addr_reg]) state <= LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state <= act_srst ? DROP : LOAD_DATA;
        LOAD_DATA: begin
          if (act_srst) begin
            state <= DROP;
          end else if (!act_full) begin
            if (pkt_valid) begin
              par_acc <= par_acc ^ data_in;
              if (len_cnt != 6'd63) len_cnt <= len_cnt + 6'd1;
            end else begin
              par_byte <= data_in;
              state    <= CHECK_PARITY;
            end
          end
        end
        CHECK_PARITY: begin
          parity_err <= (par_acc != par_byte);
          len_err    <= (len_cnt != hdr_reg[7:2]);
          state      <= DECODE_ADDRESS;
        end
        DROP: if (!pkt_valid) state <= DECODE_ADDRESS;
        default: state <= DECODE_ADDRESS;
      endcase
    end
  end

  // Watchdog: counts consecutive edges with data present and no read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      soft_reset <= 3'b000;
      for (int i = 0; i < 3; i++) wd_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (valid_out[i] && !read_enb[i]) begin
          if (wd_cnt[i] == CW'(TIMEOUT - 1)) begin
            wd_cnt[i]     <= '0;
            soft_reset[i] <= 1'b1;
          end else begin
            wd_cnt[i]     <= wd_cnt[i] + 1'b1;
            soft_reset[i] <= 1'b0;
          end
        end else begin
          wd_cnt[i]     <= '0;
          soft_reset[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: packet table plus hand-written stall, wait and watchdog sequences.
module tb_router_ctrl;

  logic       clock, resetn, pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic [2:0] write_enb, valid_out, soft_reset;
  logic [7:0] fifo_din;
  logic       lfd_state, busy, parity_err, len_err;

  router_ctrl #(.TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .write_enb(write_enb), .fifo_din(fifo_din), .lfd_state(lfd_state), .busy(busy),
    .valid_out(valid_out), .soft_reset(soft_reset), .parity_err(parity_err), .len_err(len_err)
  );

  typedef struct packed {
    logic [2:0] we;
    logic [7:0] din;
    logic       lfd;
  } wr_t;

  typedef struct {
    logic [7:0] hdr;
    int         npay;
    bit         bad_par;
    logic       exp_pe;
    logic       exp_le;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk_wr(input logic [1:0] a, input logic [7:0] d, input logic l);
    wr_t w;
    w.we  = 3'b001 << a;
    w.din = d;
    w.lfd = l;
    return w;
  endfunction

  function automatic logic [7:0] pay_byte(input logic [7:0] h, input int i);
    return h ^ 8'(i * 29 + 3);
  endfunction

  // Every FIFO write seen by the DUT is matched against the scoreboard in order.
  always @(negedge clock) begin
    if (write_enb != 3'b000) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: we=%b din=%0h, required no write", write_enb, fifo_din);
      end else begin
        chk("write", {write_enb, fifo_din, lfd_state}, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic pv);
    int n;
    n = 0;
    data_in   = d;
    pkt_valid = pv;
    @(negedge clock);
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clock);
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: busy=%b after 300 cycles, required 0", busy);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] hdr, input int npay, input bit bad_par);
    logic [7:0] par, b;
    logic       keep;
    keep = (hdr[1:0] != 2'd3);
    par  = hdr;
    if (keep) exp_q.push_back(mk_wr(hdr[1:0], hdr, 1'b1));
    send_byte(hdr, 1'b1);
    for (int i = 0; i < npay; i++) begin
      b   = pay_byte(hdr, i);
      par = par ^ b;
      if (keep) exp_q.push_back(mk_wr(hdr[1:0], b, 1'b0));
      send_byte(b, 1'b1);
    end
    if (bad_par) par = ~par;
    if (keep) exp_q.push_back(mk_wr(hdr[1:0], par, 1'b0));
    send_byte(par, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] p0, p1, par;

    vecs[0] = '{8'h11,  4, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h15,  3, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'hFD, 64, 1'b0, 1'b0, 1'b0};  // length counter saturates at 63
    vecs[3] = '{8'h08,  2, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h0E,  1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h03,  2, 1'b0, 1'b0, 1'b1};  // dropped, flags unchanged
    vecs[6] = '{8'h02,  0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'hFD, 63, 1'b0, 1'b0, 1'b0};

    resetn     = 1'b0;
    pkt_valid  = 1'b1;
    data_in    = 8'h11;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    read_enb   = 3'b000;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", write_enb, 3'b000);
    chk("rst_srst", soft_reset, 3'b000);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_lerr", len_err, 1'b0);
    @(posedge clock);
    #1;
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    @(posedge clock);
    #1;

    for (int v = 0; v < 8; v++) begin
      send_packet(vecs[v].hdr, vecs[v].npay, vecs[v].bad_par);
      @(posedge clock);
      #1;
      chk($sformatf("pkt%0d_perr", v), parity_err, vecs[v].exp_pe);
      chk($sformatf("pkt%0d_lerr", v), len_err, vecs[v].exp_le);
      chk($sformatf("pkt%0d_idle", v), busy, 1'b0);
    end

    // Wait for empty: port 2 busy for 5 cycles, header written the cycle after empty rises.
    fifo_empty = 3'b011;
    read_enb   = 3'b100;
    exp_q.push_back(mk_wr(2'd2, 8'h0A, 1'b1));
    send_byte(8'h0A, 1'b1);
    p0  = pay_byte(8'h0A, 0);
    p1  = pay_byte(8'h0A, 1);
    par = 8'h0A ^ p0 ^ p1;
    exp_q.push_back(mk_wr(2'd2, p0, 1'b0));
    data_in   = p0;
    pkt_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("wait_busy", busy, 1'b1);
      chk("wait_we", write_enb, 3'b000);
      @(posedge clock);
      #1;
    end
    fifo_empty = 3'b111;
    read_enb   = 3'b000;
    @(negedge clock);
    chk("wait_rise_busy", busy, 1'b1);
    chk("wait_rise_we", write_enb, 3'b000);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("wait_hdr_we", write_enb, 3'b100);
    chk("wait_hdr_lfd", lfd_state, 1'b1);
    @(posedge clock);
    #1;
    send_byte(p0, 1'b1);
    exp_q.push_back(mk_wr(2'd2, p1, 1'b0));
    send_byte(p1, 1'b1);
    exp_q.push_back(mk_wr(2'd2, par, 1'b0));
    send_byte(par, 1'b0);
    @(posedge clock);
    #1;
    chk("wait_perr", parity_err, 1'b0);
    chk("wait_lerr", len_err, 1'b0);

    // Full stall on port 0 mid-payload: held byte written exactly once after release.
    exp_q.push_back(mk_wr(2'd0, 8'h0C, 1'b1));
    send_byte(8'h0C, 1'b1);
    p0 = pay_byte(8'h0C, 0);
    exp_q.push_back(mk_wr(2'd0, p0, 1'b0));
    send_byte(p0, 1'b1);
    par = 8'h0C ^ p0;
    p1  = pay_byte(8'h0C, 1);
    exp_q.push_back(mk_wr(2'd0, p1, 1'b0));
    fifo_full = 3'b001;
    data_in   = p1;
    pkt_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("full_busy", busy, 1'b1);
      chk("full_we", write_enb, 3'b000);
      @(posedge clock);
      #1;
    end
    fifo_full = 3'b000;
    send_byte(p1, 1'b1);
    par = par ^ p1;
    p1  = pay_byte(8'h0C, 2);
    par = par ^ p1;
    exp_q.push_back(mk_wr(2'd0, p1, 1'b0));
    send_byte(p1, 1'b1);
    exp_q.push_back(mk_wr(2'd0, par, 1'b0));
    send_byte(par, 1'b0);
    @(posedge clock);
    #1;
    chk("full_perr", parity_err, 1'b0);
    chk("full_lerr", len_err, 1'b0);

    // Watchdog: port 1 unread for 30 edges.
    fifo_empty = 3'b101;
    #1;
    chk("valid_out", valid_out, 3'b010);
    for (int k = 1; k <= 31; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("wd_edge%0d", k), soft_reset, (k == 30) ? 3'b010 : 3'b000);
    end
    fifo_empty = 3'b111;
    @(posedge clock);
    #1;

    // Watchdog restart: read pulse on edge 20 pushes the timeout to edge 50.
    fifo_empty = 3'b101;
    for (int k = 1; k <= 51; k++) begin
      read_enb = (k == 20) ? 3'b010 : 3'b000;
      @(posedge clock);
      #1;
      chk($sformatf("wdr_edge%0d", k), soft_reset, (k == 50) ? 3'b010 : 3'b000);
    end
    read_enb   = 3'b000;
    fifo_empty = 3'b111;
    @(posedge clock);
    #1;

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
